// File: rtl/axis_ingress_fifo.sv
// axis_ingress_fifo
//
// Ingress buffer in front of the message controller. Raw 64-bit AXI-Stream beats
// (tdata/tkeep/tlast/tuser) are stored in a DEPTH-entry FIFO. The head entry is
// presented first-word-fall-through on the s_* side. Every packet's tkeep framing
// is checked on the way in. A packet with bad framing gets tuser forced high on
// its tlast beat, so the downstream error path (tlast && tuser) fires.
//
// Handshake: a beat moves on a port in the cycle where valid and ready are both
// high at the rising edge. valid never waits for ready. Once valid is raised,
// payload and valid stay stable until the transfer completes. ready may change
// freely. in_tready is !full, and s_tvalid is !empty. No beat passes straight
// through: the input side cannot write while the FIFO is full, even if the head
// is read in that cycle. The output side cannot read in the cycle an empty FIFO
// is written.
//
// Ports
//   clk, rst                 clock and asynchronous active-high reset
//   in_t*                    upstream AXI-Stream slave side
//   s_t*                     head-of-FIFO master side (to message controller)
//   level                    beats stored
//   almost_full              level >= AFULL_THRESH
//   pkt_count                tlast beats stored
//   keep_err                 one-cycle pulse after an illegal-tkeep beat is accepted
//   frame_state              current input framing state (observation only)

module axis_ingress_fifo #(
    parameter int DATA_WIDTH   = 64,
    parameter int TKEEP_WIDTH  = 8,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_tvalid,
    output logic                        in_tready,
    input  logic [DATA_WIDTH-1:0]       in_tdata,
    input  logic [TKEEP_WIDTH-1:0]      in_tkeep,
    input  logic                        in_tlast,
    input  logic                        in_tuser,
    output logic                        s_tvalid,
    input  logic                        s_tready,
    output logic [DATA_WIDTH-1:0]       s_tdata,
    output logic [TKEEP_WIDTH-1:0]      s_tkeep,
    output logic                        s_tlast,
    output logic                        s_tuser,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        almost_full,
    output logic [$clog2(DEPTH):0]      pkt_count,
    output logic                        keep_err,
    output logic [1:0]                  frame_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] ONE     = LW'(1);
    localparam logic [LW-1:0] AFULL_L = LW'(AFULL_THRESH);
    localparam logic [TKEEP_WIDTH-1:0] KEEP_ONE = TKEEP_WIDTH'(1);

    // Input framing states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BODY = 2'd1;
    localparam logic [1:0] ST_BAD  = 2'd2;

    // Storage (contents are not reset; validity comes from the pointers)
    logic [DATA_WIDTH-1:0]  data_mem [DEPTH];
    logic [TKEEP_WIDTH-1:0] keep_mem [DEPTH];
    logic [DEPTH-1:0]       last_mem;
    logic [DEPTH-1:0]       user_mem;

    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] pkt_q, pkt_d;
    logic [1:0]    state_q, state_d;
    logic          keep_err_q, keep_err_d;

    logic [AW-1:0]          wr_addr;
    logic [AW-1:0]          rd_addr;
    logic                   full;
    logic                   empty;
    logic                   wr_en;
    logic                   rd_en;
    logic [TKEEP_WIDTH-1:0] keep_plus1;
    logic                   keep_all_ones;
    logic                   keep_last_ok;
    logic                   beat_illegal;
    logic                   store_user;

    assign wr_addr = wr_ptr_q[AW-1:0];
    assign rd_addr = rd_ptr_q[AW-1:0];

    // Pointers carry one extra wrap bit, so full and empty can be told apart
    // when the addresses are equal.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_addr == rd_addr);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Reset clears the pointers, which would otherwise show "not full". The
    // explicit rst term holds in_tready low while reset is asserted.
    assign in_tready = !full && !rst;
    assign s_tvalid  = !empty;

    assign wr_en = in_tvalid && in_tready;
    assign rd_en = s_tvalid && s_tready;

    assign s_tdata = data_mem[rd_addr];
    assign s_tkeep = keep_mem[rd_addr];
    assign s_tlast = last_mem[rd_addr];
    assign s_tuser = user_mem[rd_addr];

    assign level       = level_q;
    assign pkt_count   = pkt_q;
    assign almost_full = (level_q >= AFULL_L);
    assign keep_err    = keep_err_q;
    assign frame_state = state_q;

    // A legal last-beat tkeep has the form 2^k-1 with k >= 1. Adding one to
    // such a value clears every bit that was set. For all-ones the add wraps
    // to zero, which is also legal.
    assign keep_plus1    = in_tkeep + KEEP_ONE;
    assign keep_all_ones = &in_tkeep;
    assign keep_last_ok  = (in_tkeep != '0) && ((in_tkeep & keep_plus1) == '0);
    assign beat_illegal  = in_tlast ? !keep_last_ok : !keep_all_ones;

    // The error mark is attached only to the tlast beat, because that is where
    // the consumer looks. Earlier beats keep the upstream tuser.
    assign store_user = in_tuser | (in_tlast & ((state_q == ST_BAD) | beat_illegal));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        pkt_d      = pkt_q;
        state_d    = state_q;
        keep_err_d = wr_en && beat_illegal;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end

        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase

        case ({wr_en && in_tlast, rd_en && s_tlast})
            2'b10:   pkt_d = pkt_q + ONE;
            2'b01:   pkt_d = pkt_q - ONE;
            default: pkt_d = pkt_q;
        endcase

        // Framing FSM advances only on accepted beats.
        if (wr_en) begin
            case (state_q)
                ST_IDLE, ST_BODY: begin
                    if (in_tlast) begin
                        state_d = ST_IDLE;
                    end else if (beat_illegal) begin
                        state_d = ST_BAD;
                    end else begin
                        state_d = ST_BODY;
                    end
                end
                ST_BAD: begin
                    if (in_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pkt_q      <= '0;
            state_q    <= ST_IDLE;
            keep_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pkt_q      <= pkt_d;
            state_q    <= state_d;
            keep_err_q <= keep_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_addr] <= in_tdata;
            keep_mem[wr_addr] <= in_tkeep;
            last_mem[wr_addr] <= in_tlast;
            user_mem[wr_addr] <= store_user;
        end
    end

endmodule
